// File: rtl/operand_fetch.sv
// operand_fetch: 32-entry register file with a registered operand/ALU-code
// output stage feeding the execute stage.
// Optional feature macro: WRITE_BYPASS_EN. When defined, a capture whose read
// index matches a same-cycle write (not to the zero register) loads write_data.
// Otherwise that capture loads the pre-write register contents.
//
// Valid semantics: out_valid qualifies read_data_1/read_data_2/ALUcontrol.
// There is no ready; the downstream stage holds this stage with stall, and
// flush drops the instruction entering the output register (flush > stall).
module operand_fetch #(
   parameter int DATA_WIDTH = 64,
   parameter int ZERO_REG   = 31
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [4:0]            read_reg_1,
   input  logic [4:0]            read_reg_2,
   input  logic [3:0]            alu_ctrl_in,
   input  logic                  reg_write,
   input  logic [4:0]            write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2,
   output logic [3:0]            ALUcontrol
);

   localparam logic [4:0] ZERO_IDX = ZERO_REG[4:0];

   logic [DATA_WIDTH-1:0] regs [32];
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] rd_1;
   logic [DATA_WIDTH-1:0] rd_2;

   // Writes to the zero register are dropped; stall/flush do not gate writes.
   assign wr_en = reg_write && (write_reg != ZERO_IDX);

   // Register file storage, cleared asynchronously by reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[write_reg] <= write_data;
      end
   end

   // Combinational read ports; zero register reads as 0, optional write bypass.
   always_comb begin
      rd_1 = '0;
      rd_2 = '0;
      if (read_reg_1 != ZERO_IDX) begin
         rd_1 = regs[read_reg_1];
`ifdef WRITE_BYPASS_EN
         if (wr_en && (write_reg == read_reg_1)) begin
            rd_1 = write_data;
         end
`endif
      end
      if (read_reg_2 != ZERO_IDX) begin
         rd_2 = regs[read_reg_2];
`ifdef WRITE_BYPASS_EN
         if (wr_en && (write_reg == read_reg_2)) begin
            rd_2 = write_data;
         end
`endif
      end
   end

   // Output register: flush clears valid only, stall holds everything,
   // otherwise capture every cycle (also when in_valid is low).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         read_data_1 <= '0;
         read_data_2 <= '0;
         ALUcontrol  <= 4'b0000;
      end else if (flush) begin
         out_valid   <= 1'b0;
      end else if (!stall) begin
         out_valid   <= in_valid;
         read_data_1 <= rd_1;
         read_data_2 <= rd_2;
         ALUcontrol  <= alu_ctrl_in;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenarios plus randomized traffic,
// checked against an array-based reference model and an expected queue.
module tb_operand_fetch;

   localparam int DW    = 64;
   localparam int EXP_W = 1 + 4 + DW + DW;

   logic          clock;
   logic          reset_n;
   logic          in_valid;
   logic          stall;
   logic          flush;
   logic [4:0]    read_reg_1;
   logic [4:0]    read_reg_2;
   logic [3:0]    alu_ctrl_in;
   logic          reg_write;
   logic [4:0]    write_reg;
   logic [DW-1:0] write_data;
   logic          out_valid;
   logic [DW-1:0] read_data_1;
   logic [DW-1:0] read_data_2;
   logic [3:0]    ALUcontrol;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [DW-1:0] m_rf [32];
   logic          m_valid;
   logic [3:0]    m_alu;
   logic [DW-1:0] m_d1;
   logic [DW-1:0] m_d2;

   logic [EXP_W-1:0] exp_q [$];

   operand_fetch #(.DATA_WIDTH(DW), .ZERO_REG(31)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .stall       (stall),
      .flush       (flush),
      .read_reg_1  (read_reg_1),
      .read_reg_2  (read_reg_2),
      .alu_ctrl_in (alu_ctrl_in),
      .reg_write   (reg_write),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .out_valid   (out_valid),
      .read_data_1 (read_data_1),
      .read_data_2 (read_data_2),
      .ALUcontrol  (ALUcontrol)
   );

   // clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input logic [4:0] idx);
      if (idx == 5'd31) return '0;
`ifdef WRITE_BYPASS_EN
      if (reg_write && write_reg != 5'd31 && write_reg == idx) return write_data;
`endif
      return m_rf[idx];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_valid = 1'b0;
      m_alu   = 4'b0;
      m_d1    = '0;
      m_d2    = '0;
   endtask

   task automatic set_idle();
      in_valid    = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      read_reg_1  = 5'd0;
      read_reg_2  = 5'd0;
      alu_ctrl_in = 4'b0;
      reg_write   = 1'b0;
      write_reg   = 5'd0;
      write_data  = '0;
   endtask

   task automatic drive_write(input logic [4:0] idx, input logic [DW-1:0] val);
      reg_write  = 1'b1;
      write_reg  = idx;
      write_data = val;
   endtask

   task automatic drive_capture(input logic [4:0] r1, input logic [4:0] r2, input logic [3:0] alu);
      in_valid    = 1'b1;
      read_reg_1  = r1;
      read_reg_2  = r2;
      alu_ctrl_in = alu;
   endtask

   // One clock: model predicts the output register, then DUT is compared.
   task automatic step(input string tag);
      logic [EXP_W-1:0] e;
      logic [DW-1:0] n1, n2;
      n1 = model_read(read_reg_1);
      n2 = model_read(read_reg_2);
      if (flush) begin
         m_valid = 1'b0;
      end else if (!stall) begin
         m_valid = in_valid;
         m_alu   = alu_ctrl_in;
         m_d1    = n1;
         m_d2    = n2;
      end
      if (reg_write && write_reg != 5'd31) m_rf[write_reg] = write_data;
      exp_q.push_back({m_valid, m_alu, m_d1, m_d2});
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check_eq({tag, ".valid"}, DW'(out_valid), DW'(e[EXP_W-1]));
      check_eq({tag, ".alu"}, DW'(ALUcontrol), DW'(e[2*DW+3 -: 4]));
      check_eq({tag, ".d1"}, read_data_1, e[2*DW-1 -: DW]);
      check_eq({tag, ".d2"}, read_data_2, e[DW-1:0]);
   endtask

   initial begin
      logic [DW-1:0] held1, held2;
      // reset
      set_idle();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst.valid", DW'(out_valid), '0);
      check_eq("rst.d1", read_data_1, '0);
      check_eq("rst.d2", read_data_2, '0);
      check_eq("rst.alu", DW'(ALUcontrol), '0);
      reset_n = 1'b1;

      // write X5, then capture X5/X31 with ADD
      set_idle(); drive_write(5'd5, 64'h0000_0000_DEAD_BEEF); step("w5");
      set_idle(); drive_capture(5'd5, 5'd31, 4'b0010); step("cap5");
      check_eq("cap5.d1c", read_data_1, 64'hDEAD_BEEF);
      check_eq("cap5.d2c", read_data_2, 64'h0);
      check_eq("cap5.aluc", DW'(ALUcontrol), DW'(4'b0010));
      check_eq("cap5.vc", DW'(out_valid), 64'd1);

      // zero register write discarded, same index on both ports
      set_idle(); drive_write(5'd31, '1); step("w31");
      set_idle(); drive_capture(5'd31, 5'd31, 4'b0001); step("r31");
      check_eq("r31.d1c", read_data_1, 64'h0);
      set_idle(); drive_capture(5'd5, 5'd5, 4'b0000); step("same");

      // same-cycle write and capture of X7
      set_idle(); drive_write(5'd7, 64'd1); step("w7a");
      set_idle(); drive_write(5'd7, 64'd2); drive_capture(5'd7, 5'd0, 4'b0110); step("w7b");
`ifdef WRITE_BYPASS_EN
      check_eq("byp.d1", read_data_1, 64'd2);
`else
      check_eq("byp.d1", read_data_1, 64'd1);
`endif

      // stall holds outputs while X3 is rewritten
      set_idle(); drive_write(5'd3, 64'h10); step("w3");
      set_idle(); drive_capture(5'd3, 5'd3, 4'b0010); step("cap3");
      held1 = 64'h10;
      for (int i = 0; i < 3; i++) begin
         set_idle(); stall = 1'b1; drive_capture(5'd3, 5'd3, 4'b0001);
         drive_write(5'd3, 64'h20); step("stall");
         check_eq("stall.d1c", read_data_1, held1);
      end
      set_idle(); drive_capture(5'd3, 5'd0, 4'b0010); step("post");
      check_eq("post.d1c", read_data_1, 64'h20);

      // stall+flush with in_valid: valid drops, data held
      held1 = read_data_1; held2 = read_data_2;
      set_idle(); stall = 1'b1; flush = 1'b1; drive_capture(5'd5, 5'd5, 4'b0110); step("sf");
      check_eq("sf.vc", DW'(out_valid), 64'd0);
      check_eq("sf.d1c", read_data_1, held1);
      check_eq("sf.d2c", read_data_2, held2);

      // mid-cycle async reset with a valid output
      set_idle(); drive_capture(5'd5, 5'd3, 4'b0010); step("pre");
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("arst.valid", DW'(out_valid), '0);
      check_eq("arst.d1", read_data_1, '0);
      check_eq("arst.d2", read_data_2, '0);
      check_eq("arst.alu", DW'(ALUcontrol), '0);
      // a write held across a reset edge is lost
      drive_write(5'd9, 64'h55);
      @(posedge clock);
      #1;
      model_reset();
      set_idle();
      reset_n = 1'b1;
      set_idle(); drive_capture(5'd5, 5'd3, 4'b0010); step("rd0a");
      set_idle(); drive_capture(5'd9, 5'd7, 4'b0000); step("rd0b");

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         set_idle();
         in_valid    = 1'($urandom_range(0, 1));
         stall       = ($urandom_range(0, 3) == 0);
         flush       = ($urandom_range(0, 7) == 0);
         read_reg_1  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         read_reg_2  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         alu_ctrl_in = 4'($urandom_range(0, 15));
         reg_write   = 1'($urandom_range(0, 1));
         write_reg   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         write_data  = {32'($urandom), 32'($urandom)};
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 64, operand and register width.
REQ-002 Parameter ZERO_REG, default 31, register index hard-wired to zero.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with clock and reset_n listed first in the port list.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  decode slot holds a valid instruction.
REQ-007 stall  input  1  hold output register.
REQ-008 flush  input  1  kill the instruction entering the output register.
REQ-009 read_reg_1  input  5  source register index A.
REQ-010 read_reg_2  input  5  source register index B.
REQ-011 alu_ctrl_in  input  4  ALU operation code from decode (0000 AND, 0001 OR, 0010 ADD, 0110 SUB).
REQ-012 reg_write  input  1  writeback enable.
REQ-013 write_reg  input  5  writeback register index.
REQ-014 write_data  input  DATA_WIDTH  writeback value.
REQ-015 out_valid  output  1  output register holds a valid instruction.
REQ-016 read_data_1  output  DATA_WIDTH  registered operand A to the ALU.
REQ-017 read_data_2  output  DATA_WIDTH  registered operand B to the ALU.
REQ-018 ALUcontrol  output  4  registered ALU operation code.

Function
REQ-019 The register file SHALL hold 32 entries of DATA_WIDTH bits.
REQ-020 Reads of ZERO_REG SHALL return 0.
REQ-021 Writes to ZERO_REG SHALL be discarded.
REQ-022 A write SHALL occur on the rising edge when reg_write=1 and write_reg!=ZERO_REG.
REQ-023 Writes SHALL occur regardless of stall or flush.
REQ-024 Output register update priority SHALL be flush > stall > capture.
REQ-025 Flush: out_valid<=0; read_data_1, read_data_2 and ALUcontrol SHALL hold their values.
REQ-026 Stall (no flush): all outputs SHALL hold their values, including out_valid and operand data, even if the source register is written that cycle.
REQ-027 Capture: out_valid<=in_valid, ALUcontrol<=alu_ctrl_in, read_data_1<=RF[read_reg_1], read_data_2<=RF[read_reg_2].
REQ-028 Capture SHALL occur even when in_valid=0.
REQ-029 Read-to-output latency SHALL be exactly 1 cycle.
REQ-030 Both read ports MAY address the same register, and both outputs SHALL then receive the same value.

Reset
REQ-031 reset_n=0 SHALL asynchronously clear all 32 entries to 0 and clear out_valid, read_data_1, read_data_2 and ALUcontrol to 0.
REQ-032 A write or capture coinciding with asserted reset SHALL be lost.
REQ-033 Normal operation SHALL resume on the first rising edge after reset_n returns to 1.

Configuration
REQ-034 The macro WRITE_BYPASS_EN SHALL select same-cycle write/read behaviour.
REQ-035 With WRITE_BYPASS_EN defined, a capture whose read index equals a same-cycle valid write index (not ZERO_REG) SHALL load write_data.
REQ-036 Without WRITE_BYPASS_EN, that same capture SHALL load the pre-write register contents.

Verification
REQ-037 Reset, then write X5=0x0000_0000_DEAD_BEEF, then capture read_reg_1=5, read_reg_2=31, alu_ctrl_in=0010, in_valid=1 -> next cycle read_data_1=0xDEADBEEF, read_data_2=0, ALUcontrol=0010, out_valid=1.
REQ-038 Write X31=0xFFFF_FFFF_FFFF_FFFF, then read X31 -> read_data=0.
REQ-039 X7=1, then same cycle write X7=2 and capture X7 -> read_data_1=2 with WRITE_BYPASS_EN, 1 without it.
REQ-040 Outputs valid with X3=0x10, then stall=1 for 3 cycles while writing X3=0x20 -> outputs unchanged for those 3 cycles; after release a capture of X3 yields 0x20.
REQ-041 stall=1 and flush=1 with in_valid=1 -> out_valid=0 next cycle, data outputs unchanged.
REQ-042 Assert reset_n=0 mid-cycle with out_valid=1 -> all outputs 0 immediately, before the next clock edge; a subsequent read of any register returns 0.
